// File: rtl/fp_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_divider_if
// Purpose  : Operand/result strobe-handshake bundle shared by the FP divider
//            and multiplier.
// Revision : 1.0  initial release
// ============================================================================
interface fp_divider_if #(
    parameter int N = 32
);
    logic [N-1:0] input_a;
    logic         input_a_stb;
    logic         input_a_ack;
    logic [N-1:0] input_b;
    logic         input_b_stb;
    logic         input_b_ack;
    logic [N-1:0] output_z;
    logic         output_z_stb;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );
endinterface
`default_nettype wire

// File: rtl/fp_divider.sv
`default_nettype none
// ============================================================================
// Module   : fp_divider
// Purpose  : Multi-cycle IEEE-style floating-point divider z = a / b with a
//            restoring quotient loop and round-to-nearest-even.
//            Optional macro FP_DIVIDER_SUBNORMAL_EN enables subnormal support.
// Revision : 1.0  initial release
// ============================================================================
module fp_divider #(
    parameter int N        = 32,
    parameter int EXPONENT = 8,
    parameter int FRACTION = 23
) (
    input wire          clk,
    input wire          rst,
    fp_divider_if.slave bus
);

    localparam int c_EW   = EXPONENT + 2;
    localparam int c_MW   = FRACTION + 1;
    localparam int c_QW   = FRACTION + 4;
    localparam int c_RW   = FRACTION + 3;
    localparam int c_CW   = $clog2(FRACTION + 4);
    localparam int c_BIAS = (2 ** (EXPONENT - 1)) - 1;

    localparam logic signed [c_EW-1:0] c_BIAS_E = c_EW'(c_BIAS);
    localparam logic signed [c_EW-1:0] c_EMIN   = c_EW'(1 - c_BIAS);
    localparam logic signed [c_EW-1:0] c_ONE_E  = c_EW'(1);

    typedef enum logic [3:0] {
        S_GET_A         = 4'd0,
        S_GET_B         = 4'd1,
        S_UNPACK        = 4'd2,
        S_SPECIAL_CASES = 4'd3,
        S_DIVIDE_0      = 4'd4,
        S_DIVIDE_1      = 4'd5,
        S_NORMALISE     = 4'd6,
        S_ROUND         = 4'd7,
        S_PACK          = 4'd8,
        S_PUT_Z         = 4'd9,
        S_NORMALISE_IN  = 4'd10,
        S_DENORM        = 4'd11
    } state_t;

    state_t r_state, w_state_next;

    logic [N-1:0]           r_a, r_b, r_res, r_z;
    logic                   r_a_ack, r_b_ack, r_z_stb;
    logic                   r_a_s, r_b_s, r_z_s;
    logic [c_MW-1:0]        r_a_m, r_b_m, r_z_m;
    logic signed [c_EW-1:0] r_a_e, r_b_e, r_z_e;
    logic [c_RW-1:0]        r_rem;
    logic [c_QW-1:0]        r_q;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_guard, r_round, r_sticky;

    // Operand classification straight from the captured words.
    logic [EXPONENT-1:0] w_a_exp, w_b_exp, w_exp_field;
    logic [FRACTION-1:0] w_a_frac, w_b_frac;
    logic w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_zero, w_b_zero;
    logic w_nan_case, w_inf_case, w_zero_case, w_special;
    logic w_need_norm_in, w_to_denorm;
    logic                   w_rem_ge;
    logic [c_RW-1:0]        w_rem_next;
    logic [c_QW-1:0]        w_qn;
    logic signed [c_EW-1:0] w_ze_n;
    logic                   w_round_up;

    assign w_a_exp  = r_a[N-2 -: EXPONENT];
    assign w_b_exp  = r_b[N-2 -: EXPONENT];
    assign w_a_frac = r_a[FRACTION-1:0];
    assign w_b_frac = r_b[FRACTION-1:0];
    assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
    assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
    assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
    assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);
`ifdef FP_DIVIDER_SUBNORMAL_EN
    assign w_a_zero = (w_a_exp == '0) && (w_a_frac == '0);
    assign w_b_zero = (w_b_exp == '0) && (w_b_frac == '0);
`else
    // Subnormal operands collapse to signed zero.
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
`endif

    assign w_nan_case  = w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero);
    assign w_inf_case  = w_a_inf || w_b_zero;
    assign w_zero_case = w_a_zero || w_b_inf;
    assign w_special   = w_nan_case || w_inf_case || w_zero_case;

    assign w_rem_ge   = (r_rem >= {2'b00, r_b_m});
    assign w_rem_next = w_rem_ge ? (r_rem - {2'b00, r_b_m}) : r_rem;

    assign w_qn   = r_q[c_QW-1] ? r_q : (r_q << 1);
    assign w_ze_n = r_q[c_QW-1] ? r_z_e : (r_z_e - c_ONE_E);

    assign w_round_up  = r_guard && (r_round || r_sticky || r_z_m[0]);
    assign w_exp_field = r_z_m[FRACTION] ? EXPONENT'(r_z_e + c_BIAS_E) : '0;

`ifdef FP_DIVIDER_SUBNORMAL_EN
    localparam logic signed [c_EW-1:0] c_EDEEP = c_EMIN - c_EW'(FRACTION + 2);
    logic w_a_m_ok, w_b_m_ok;
    assign w_a_m_ok       = r_a_m[FRACTION] || r_a_m[FRACTION-1];
    assign w_b_m_ok       = r_b_m[FRACTION] || r_b_m[FRACTION-1];
    assign w_need_norm_in = !r_a_m[FRACTION] || !r_b_m[FRACTION];
    assign w_to_denorm    = (w_ze_n < c_EMIN);
`else
    assign w_need_norm_in = 1'b0;
    assign w_to_denorm    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_GET_A;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_GET_A:         if (bus.input_a_stb) w_state_next = S_GET_B;
            S_GET_B:         if (bus.input_b_stb) w_state_next = S_UNPACK;
            S_UNPACK:        w_state_next = S_SPECIAL_CASES;
            S_SPECIAL_CASES: begin
                if (w_special)           w_state_next = S_PUT_Z;
                else if (w_need_norm_in) w_state_next = S_NORMALISE_IN;
                else                     w_state_next = S_DIVIDE_0;
            end
`ifdef FP_DIVIDER_SUBNORMAL_EN
            S_NORMALISE_IN:  if (w_a_m_ok && w_b_m_ok) w_state_next = S_DIVIDE_0;
            S_DENORM:        if (!(r_z_e < c_EMIN)) w_state_next = S_ROUND;
`endif
            S_DIVIDE_0:      w_state_next = S_DIVIDE_1;
            S_DIVIDE_1:      if (r_cnt == '0) w_state_next = S_NORMALISE;
            S_NORMALISE:     w_state_next = w_to_denorm ? S_DENORM : S_ROUND;
            S_ROUND:         w_state_next = S_PACK;
            S_PACK:          w_state_next = S_PUT_Z;
            S_PUT_Z:         w_state_next = S_GET_A;
            default:         w_state_next = S_GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_z      <= '0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_z_stb  <= 1'b0;
            r_a_s    <= 1'b0;
            r_b_s    <= 1'b0;
            r_z_s    <= 1'b0;
            r_a_m    <= '0;
            r_b_m    <= '0;
            r_z_m    <= '0;
            r_a_e    <= '0;
            r_b_e    <= '0;
            r_z_e    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_guard  <= 1'b0;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_z_stb <= 1'b0;
            case (r_state)
                S_GET_A: if (bus.input_a_stb) begin
                    r_a     <= bus.input_a;
                    r_a_ack <= 1'b1;
                end
                S_GET_B: if (bus.input_b_stb) begin
                    r_b     <= bus.input_b;
                    r_b_ack <= 1'b1;
                end
                S_UNPACK: begin
                    r_a_s <= r_a[N-1];
                    r_b_s <= r_b[N-1];
                    r_a_m <= {(w_a_exp != '0), w_a_frac};
                    r_b_m <= {(w_b_exp != '0), w_b_frac};
                    r_a_e <= (w_a_exp == '0) ? c_EMIN : ($signed({2'b00, w_a_exp}) - c_BIAS_E);
                    r_b_e <= (w_b_exp == '0) ? c_EMIN : ($signed({2'b00, w_b_exp}) - c_BIAS_E);
                end
                S_SPECIAL_CASES: begin
                    if (w_nan_case)
                        r_res <= {1'b1, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};
                    else if (w_inf_case)
                        r_res <= {r_a_s ^ r_b_s, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
                    else if (w_zero_case)
                        r_res <= {r_a_s ^ r_b_s, {(N-1){1'b0}}};
                end
`ifdef FP_DIVIDER_SUBNORMAL_EN
                S_NORMALISE_IN: begin
                    if (!r_a_m[FRACTION]) begin
                        r_a_m <= r_a_m << 1;
                        r_a_e <= r_a_e - c_ONE_E;
                    end
                    if (!r_b_m[FRACTION]) begin
                        r_b_m <= r_b_m << 1;
                        r_b_e <= r_b_e - c_ONE_E;
                    end
                end
                S_DENORM: if (r_z_e < c_EMIN) begin
                    r_z_m    <= r_z_m >> 1;
                    r_guard  <= r_z_m[0];
                    r_round  <= r_guard;
                    r_sticky <= r_sticky | r_round;
                    r_z_e    <= r_z_e + c_ONE_E;
                end
`endif
                S_DIVIDE_0: begin
                    r_z_s <= r_a_s ^ r_b_s;
                    r_z_e <= r_a_e - r_b_e;
                    r_rem <= {2'b00, r_a_m};
                    r_q   <= '0;
                    r_cnt <= c_CW'(FRACTION + 3);
                end
                S_DIVIDE_1: begin
                    r_q   <= {r_q[c_QW-2:0], w_rem_ge};
                    r_rem <= w_rem_next << 1;
                    r_cnt <= r_cnt - c_CW'(1);
                end
                // Quotient lies in (0.5, 2): at most one left shift realigns it.
                S_NORMALISE: begin
                    r_z_m    <= w_qn[c_QW-1 -: c_MW];
                    r_guard  <= w_qn[2];
                    r_round  <= w_qn[1];
                    r_sticky <= w_qn[0] | (r_rem != '0);
                    r_z_e    <= w_ze_n;
`ifdef FP_DIVIDER_SUBNORMAL_EN
                    if (w_ze_n < c_EDEEP) begin
                        r_z_m    <= '0;
                        r_guard  <= 1'b0;
                        r_round  <= 1'b0;
                        r_sticky <= 1'b0;
                        r_z_e    <= c_EMIN;
                    end
`endif
                end
                S_ROUND: if (w_round_up) begin
                    if (&r_z_m) begin
                        r_z_m <= {1'b1, {FRACTION{1'b0}}};
                        r_z_e <= r_z_e + c_ONE_E;
                    end else begin
                        r_z_m <= r_z_m + c_MW'(1);
                    end
                end
                S_PACK: begin
                    if (r_z_e > c_BIAS_E)
                        r_res <= {r_z_s, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
                    else if (r_z_e < c_EMIN)
                        r_res <= {r_z_s, {(N-1){1'b0}}};
                    else
                        r_res <= {r_z_s, w_exp_field, r_z_m[FRACTION-1:0]};
                end
                S_PUT_Z: begin
                    r_z     <= r_res;
                    r_z_stb <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.input_a_ack  = r_a_ack;
    assign bus.input_b_ack  = r_b_ack;
    assign bus.output_z     = r_z;
    assign bus.output_z_stb = r_z_stb;

endmodule
`default_nettype wire

// File: tb/tb_fp_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_divider
// Purpose  : Directed self-checking bench for fp_divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_divider;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    fp_divider_if #(.N(32)) bus ();

    fp_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction: a then b, then count edges from b capture to output strobe.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_z, input int exp_lat);
        int lat;
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        tick();
        check({tag, "_a_ack"}, 32'(bus.input_a_ack), 32'd1);
        bus.input_a_stb = 1'b0;
        bus.input_b     = b;
        bus.input_b_stb = 1'b1;
        tick();
        check({tag, "_a_ack_pulse"}, 32'(bus.input_a_ack), 32'd0);
        check({tag, "_b_ack"}, 32'(bus.input_b_ack), 32'd1);
        bus.input_b_stb = 1'b0;
        tick();
        lat = 1;
        check({tag, "_b_ack_pulse"}, 32'(bus.input_b_ack), 32'd0);
        while (!bus.output_z_stb && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_z"}, bus.output_z, exp_z);
        tick();
        check({tag, "_stb_pulse"}, 32'(bus.output_z_stb), 32'd0);
        check({tag, "_z_hold"}, bus.output_z, exp_z);
    endtask

    initial begin : stimulus
        int lat;
        int b_acks;
        logic seen_stb;

        rst = 1'b1;
        bus.input_a     = '0;
        bus.input_a_stb = 1'b0;
        bus.input_b     = '0;
        bus.input_b_stb = 1'b0;
        tick();
        tick();
        check("reset_z",     bus.output_z, 32'h0);
        check("reset_stb",   32'(bus.output_z_stb), 32'd0);
        check("reset_a_ack", 32'(bus.input_a_ack), 32'd0);
        check("reset_b_ack", 32'(bus.input_b_ack), 32'd0);
        rst = 1'b0;
        tick();

        run_div("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 34);
        run_div("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 34);
        run_div("one_by_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 34);
        run_div("pos_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 3);
        run_div("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 3);
        run_div("zero_zero",   32'h00000000, 32'h00000000, 32'hFFC00000, 3);
        run_div("inf_inf",     32'h7F800000, 32'h7F800000, 32'hFFC00000, 3);
        run_div("two_by_inf",  32'h40000000, 32'h7F800000, 32'h00000000, 3);
        run_div("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 34);
`ifdef FP_DIVIDER_SUBNORMAL_EN
        run_div("underflow",   32'h00800000, 32'h40000000, 32'h00400000, 36);
`else
        run_div("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 34);
`endif

        // b strobe held from get_a through the divide loop.
        bus.input_a     = 32'h40C00000;
        bus.input_b     = 32'h40000000;
        bus.input_b_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hs_b_early", 32'(bus.input_b_ack), 32'd0);
        end
        bus.input_a_stb = 1'b1;
        tick();
        check("hs_a_ack", 32'(bus.input_a_ack), 32'd1);
        check("hs_b_not_yet", 32'(bus.input_b_ack), 32'd0);
        bus.input_a_stb = 1'b0;
        tick();
        check("hs_b_ack", 32'(bus.input_b_ack), 32'd1);
        lat    = 0;
        b_acks = 0;
        do begin
            tick();
            lat++;
            b_acks += int'(bus.input_b_ack);
        end while (!bus.output_z_stb && lat < 100);
        check("hs_b_ack_in_loop", 32'(b_acks), 32'd0);
        check("hs_latency", 32'(lat), 32'd34);
        check("hs_z", bus.output_z, 32'h40400000);
        bus.input_b_stb = 1'b0;
        tick();

        // Asynchronous reset in the middle of the divide loop.
        bus.input_a_stb = 1'b1;
        tick();
        bus.input_a_stb = 1'b0;
        bus.input_b_stb = 1'b1;
        tick();
        bus.input_b_stb = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_z",     bus.output_z, 32'h0);
        check("arst_stb",   32'(bus.output_z_stb), 32'd0);
        check("arst_a_ack", 32'(bus.input_a_ack), 32'd0);
        check("arst_b_ack", 32'(bus.input_b_ack), 32'd0);
        tick();
        rst = 1'b0;
        seen_stb = 1'b0;
        repeat (40) begin
            tick();
            seen_stb |= bus.output_z_stb;
        end
        check("arst_no_stb", 32'(seen_stb), 32'd0);

        // Reset landing while an ack pulse is high drops it before the next edge.
        bus.input_a     = 32'h40C00000;
        bus.input_a_stb = 1'b1;
        tick();
        check("arst2_a_ack_hi", 32'(bus.input_a_ack), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst2_a_ack_lo", 32'(bus.input_a_ack), 32'd0);
        bus.input_a_stb = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        run_div("post_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
